// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory access controller: bridges MAR/MDR to a variable-latency word SRAM,
// steering byte lanes, sign-extending byte reads and pulsing r on completion or abort.
module lc3b_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  output logic        r,
  output logic [15:0] rd_data,
  output logic        unaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          word_q, lane_q, ua_p, err_p;
  logic          is_ua, tmo;
  logic [7:0]    rbyte;

  assign is_ua = data_size & mar[0];
  assign tmo   = (cnt == TMO_LAST);
  assign rbyte = lane_q ? mem_rdata[15:8] : mem_rdata[7:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mio_en) state_nx = is_ua ? DONE : ACCESS;
      ACCESS:  if (mem_ack || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      r         <= 1'b0;
      unaligned <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      cnt       <= '0;
      word_q    <= 1'b0;
      lane_q    <= 1'b0;
      ua_p      <= 1'b0;
      err_p     <= 1'b0;
    end else begin
      state     <= state_nx;
      r         <= 1'b0;
      unaligned <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: if (mio_en) begin
          ua_p  <= is_ua;
          err_p <= 1'b0;
          if (!is_ua) begin
            mem_addr <= mar[15:1];
            mem_we   <= r_w;
            mem_req  <= 1'b1;
            cnt      <= '0;
            word_q   <= data_size;
            lane_q   <= mar[0];
            // Byte writes replicate the byte on both lanes; the enables pick one.
            if (r_w) mem_wdata <= data_size ? mdr : {mdr[7:0], mdr[7:0]};
            mem_be <= (r_w && !data_size) ? (mar[0] ? 2'b10 : 2'b01) : 2'b11;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) rd_data <= word_q ? mem_rdata : {{8{rbyte[7]}}, rbyte};
          end else if (tmo) begin
            mem_req <= 1'b0;
            err_p   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          r         <= 1'b1;
          unaligned <= ua_p;
          bus_err   <= err_p;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Randomized bench for lc3b_mem_ctrl: each access is predicted from the transaction
// rules (finish cycle, flags, lane steering, sign extension) and checked cycle by cycle.
module tb_lc3b_mem_ctrl;
  localparam int TMO = 15;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mio_en = 0, r_w = 0, data_size = 0, mem_ack = 0;
  logic [15:0] mar = 0, mdr = 0, mem_rdata = 0;
  logic        r, unaligned, bus_err, mem_req, mem_we;
  logic [15:0] rd_data, mem_wdata;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;

  int nvec = 0, nerr = 0;
  logic [15:0] exp_rd = 0;

  lc3b_mem_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .mio_en(mio_en), .r_w(r_w), .data_size(data_size),
    .mar(mar), .mdr(mdr), .r(r), .rd_data(rd_data), .unaligned(unaligned),
    .bus_err(bus_err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".r"}, r, 0);
    chk({tag, ".req"}, mem_req, 0);
    chk({tag, ".flags"}, {unaligned, bus_err, mem_we}, 0);
    chk({tag, ".be"}, mem_be, 0);
    chk({tag, ".addr"}, mem_addr, 0);
    chk({tag, ".wdata"}, mem_wdata, 0);
    chk({tag, ".rd"}, rd_data, 0);
  endtask

  // Scramble the ignored inputs while an access is in flight.
  task automatic scramble();
    mar = 16'($urandom); mdr = 16'($urandom);
    r_w = 1'($urandom); data_size = 1'($urandom); mio_en = 1'($urandom);
  endtask

  // dly = number of ACCESS cycles without ack before ack is presented.
  task automatic access(input bit rw, input bit ds, input logic [15:0] a, input logic [15:0] d,
                        input int dly, input logic [15:0] rdat);
    int e; bit err; logic [7:0] b; logic [15:0] wd; logic [1:0] be;
    mio_en = 1; r_w = rw; data_size = ds; mar = a; mdr = d; mem_ack = 0;
    @(negedge clk);
    if (ds && a[0]) begin
      chk("ua.req", mem_req, 0);
      chk("ua.r0", r, 0);
      scramble();
      @(negedge clk);
      chk("ua.r", {r, unaligned, bus_err}, 3'b110);
      chk("ua.req1", mem_req, 0);
      chk("ua.rd", rd_data, exp_rd);
    end else begin
      wd = ds ? d : 16'((d & 16'h00FF) * 257);
      be = (rw && !ds) ? (a[0] ? 2'd2 : 2'd1) : 2'd3;
      chk("setup.req", mem_req, 1);
      chk("setup.addr", mem_addr, a >> 1);
      chk("setup.we", mem_we, rw);
      chk("setup.be", mem_be, be);
      if (rw) chk("setup.wdata", mem_wdata, wd);
      err = (dly + 1 > TMO);
      e   = err ? TMO : dly + 1;
      if (!rw && !err) begin
        b = a[0] ? rdat[15:8] : rdat[7:0];
        exp_rd = ds ? rdat : (b >= 8'h80 ? 16'hFF00 + b : 16'(b));
      end
      for (int n = 1; n <= e + 1; n++) begin
        scramble();
        mem_ack   = (n == dly + 1) || (n == e + 1 && $urandom_range(1) == 1);
        mem_rdata = (n == dly + 1) ? rdat : 16'($urandom);
        @(negedge clk);
        if (n < e) begin
          chk("wait.req", mem_req, 1);
          chk("wait.r", r, 0);
        end else if (n == e) begin
          chk("end.req", mem_req, 0);
          chk("end.r", r, 0);
        end else begin
          chk("done.r", {r, unaligned, bus_err}, {1'b1, 1'b0, err});
          chk("done.rd", rd_data, exp_rd);
        end
      end
    end
    mio_en = 0; mem_ack = 0;
    @(negedge clk);
    chk("post.r", {r, unaligned, bus_err}, 0);
  endtask

  initial begin
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    // directed cases
    access(0, 1, 16'h3000, 16'h0, 3, 16'h8123);
    chk("t1.rd", rd_data, 16'h8123);
    access(0, 0, 16'h3001, 16'h0, 1, 16'h80FF);
    chk("t2a.rd", rd_data, 16'hFF80);
    access(0, 0, 16'h3000, 16'h0, 0, 16'h80FF);
    chk("t2b.rd", rd_data, 16'hFFFF);
    access(1, 0, 16'h4001, 16'h12AB, 2, 16'h5555);
    chk("t3a.wd", {mem_be, mem_wdata}, {2'b10, 16'hABAB});
    access(1, 1, 16'h4000, 16'h12AB, 0, 16'h5555);
    chk("t3b.wd", {mem_be, mem_wdata}, {2'b11, 16'h12AB});
    chk("t3.rd", rd_data, 16'hFFFF);
    access(0, 1, 16'h3003, 16'h0, 0, 16'h0);
    access(0, 1, 16'h2000, 16'h0, TMO + 5, 16'h1234);
    access(0, 1, 16'h2002, 16'h0, TMO, 16'h4321);
    access(0, 1, 16'h2004, 16'h0, TMO - 1, 16'h7777);
    chk("t5.rd", rd_data, 16'h7777);
    // reset in the middle of an access
    mio_en = 1; r_w = 0; data_size = 1; mar = 16'h1234;
    @(negedge clk);
    mio_en = 0;
    @(negedge clk);
    chk("t6.req", mem_req, 1);
    #2 reset = 1;
    #1 chk_reset_vals("t6");
    exp_rd = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("t6.idle", {r, mem_req}, 0);
    access(0, 1, 16'h0100, 16'h0, 2, 16'hBEEF);
    // random traffic
    for (int i = 0; i < 250; i++) begin
      int dly;
      dly = ($urandom_range(7) == 0) ? $urandom_range(TMO + 3) : $urandom_range(5);
      access(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), dly, 16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
